dcp_mem_write: RTL
==================

// Module: dcp_mem_write
// PURPOSE
//  Debug-command processor for the memory-write ("E") command, the writer counterpart of the memory-dump command.
//  On start it takes a hex address from the serial RX byte stream. It then prints an "AAAAAAAA: " prompt on TX,
//  reads one hex data word, writes it to memory and advances the address. This repeats until an empty data token.
//  Sits beside the other DCP command blocks; shares the RX/TX byte handshakes and the debug memory write port.
// PARAMETERS
//  ADDR_W     32  memory address width (prompt always prints 8 hex digits, zero-extended)
//  DATA_W     32  memory data width
//  ADDR_STEP  1   address increment per written word (modulo 2^ADDR_W)
// PORTS
//  clk        in   1       system clock
//  rstn       in   1       asynchronous, active-low reset
//  we         in   1       start pulse; sampled only in IDLE
//  last_addr  in   ADDR_W  next address left by the previous write command
//  end_addr   out  ADDR_W  next address after this command (valid with finish, held until next finish)
//  finish     out  1       one-cycle pulse at command end
//  d_rx       in   8       RX byte
//  vld_rx     in   1       RX byte valid
//  rdy_rx     out  1       RX byte accepted when vld_rx & rdy_rx
//  d_tx       out  8       TX byte
//  vld_tx     out  1       TX byte valid
//  rdy_tx     in   1       TX sink ready; byte transferred when vld_tx & rdy_tx
//  mem_addr   out  ADDR_W  memory write address
//  mem_wdata  out  DATA_W  memory write data
//  mem_we     out  1       one-cycle write strobe; memory captures on the same edge and has no stall
// BEHAVIOUR
//  Reset: state IDLE; rdy_rx, vld_tx, mem_we and finish = 0; d_tx, mem_addr, mem_wdata and end_addr = 0; token cleared.
//  Tokenizer (active only in SCAN_A and SCAN_D, rdy_rx=1 there, 0 elsewhere):
//   - The block consumes one byte per accepted handshake.
//   - Digits 0-9, a-f and A-F give acc = {acc[DATA_W-5:0], nib}, so only the last 8 digits are kept.
//   - Terminators are 0x20, 0x0A and 0x0D. The token is empty if no digit was seen since its start.
//   - Any other byte is consumed and ignored; acc and the digit count are unchanged.
//  States:
//   IDLE    -> SCAN_A on we=1; we is ignored in every other state.
//   SCAN_A  -> on terminator: addr = nonempty ? acc : last_addr; go to PROMPT.
//   PROMPT  -> sends 10 bytes: 8 upper-case hex digits of addr (MSB first), ':', ' '. Then -> SCAN_D.
//   SCAN_D  -> on terminator: nonempty -> WRITE with wdata = acc; empty -> DONE.
//   WRITE   -> mem_we=1 for exactly 1 cycle with mem_addr=addr, mem_wdata=wdata; addr += ADDR_STEP (wraps); -> PROMPT.
//   DONE    -> finish=1 for 1 cycle; end_addr = addr; -> IDLE.
//  TX rules:
//   - vld_tx is never dropped and d_tx never changes while vld_tx & ~rdy_tx.
//   - Next byte is presented the cycle after the transfer; minimum 1 byte per 2 cycles is acceptable.
//  Latency:
//   - Terminator accepted in SCAN_D -> mem_we on the next cycle.
//   - mem_we -> first prompt byte valid on the next cycle.
//   - Terminator accepted in SCAN_D with an empty token -> finish on the next cycle.
//  Boundaries:
//   - Address wraps 0xFFFFFFFF -> 0x00000000 with no error.
//   - More than 8 digits: the upper digits are lost.
//   - Leading terminators in SCAN_A count as an empty token, so last_addr is used.
//   - vld_rx outside the scan states is not consumed (rdy_rx=0).
//   - rdy_tx stuck low stalls PROMPT indefinitely; there is no timeout.
//   - rstn low mid-command aborts: no further mem_we; the partial token is discarded; end_addr is not updated.
// STRUCTURE
//  Shared package dcp_pkg:
//   - ASCII constants: SPACE, LF, CR, COLON.
//   - State encoding typedef.
//   - Functions ascii2nib/is_hex and nib2ascii, reused by the other DCP command blocks.
//  One sub-module, dcp_word_tx: serializes {ADDR_W word, suffix bytes} onto d_tx/vld_tx/rdy_tx.
//   - Interface: start and done pulses.
//  The top holds the FSM, tokenizer and address/data registers.
// TESTING
//  1. we; RX "10 " "DEADBEEF\n" "\n" -> TX "00000010: " then "00000011: ";
//     one mem_we (0x10, 0xDEADBEEF); finish; end_addr = 0x11.
//  2. last_addr = 0x40; RX " " "1 2 \n" -> writes (0x40, 1) and (0x41, 2); end_addr = 0x42;
//     three prompts 0x40, 0x41, 0x42.
//  3. RX "FFFFFFFF 5 \n" -> write (0xFFFFFFFF, 5); next prompt "00000000: "; end_addr = 0.
//  4. RX "123456789Ab " as data -> mem_wdata = 0x456789AB; RX "1g2 " -> 0x12 ('g' ignored).
//  5. rdy_tx random ~30% duty during PROMPT -> byte sequence exact; no byte dropped or repeated;
//     d_tx stable while stalled.
//  6. rstn asserted after "7 3" with no terminator -> no mem_we, no finish;
//     after release, we plus "\n\n" -> finish with end_addr = last_addr.

Source files
------------

// File: rtl/dcp_pkg.sv
// Shared definitions for the debug-command processor blocks:
// ASCII constants, the command FSM encoding and hex/ASCII helpers.
package dcp_pkg;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] COLON = 8'h3A;

  localparam int PROMPT_DIGITS = 8;
  localparam int PROMPT_BYTES  = PROMPT_DIGITS + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN_A,
    S_PROMPT,
    S_SCAN_D,
    S_WRITE,
    S_DONE
  } dcp_state_e;

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) ||
           (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == SPACE) || (b == LF) || (b == CR);
  endfunction

  // Letters of either case share the low nibble 1..6, so add 9 to get a..f.
  function automatic logic [3:0] ascii2nib(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    return b[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/dcp_word_tx.sv
// Serializes a word as 8 upper-case hex digits (MSB first) followed by two
// suffix bytes onto the TX byte handshake; start/done pulses frame the job.
module dcp_word_tx
  import dcp_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  input  logic [15:0]       suffix,
  output logic [7:0]        d_tx,
  output logic              vld_tx,
  input  logic              rdy_tx,
  output logic              done
);

  localparam logic [3:0] LAST_IDX = 4'(PROMPT_BYTES - 1);

  logic [31:0] word_q;
  logic [31:0] word_ext;
  logic [3:0]  idx;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [3:0] i,
                                          input logic [15:0] sfx);
    logic [31:0] sh;
    sh = w << {i, 2'b00};
    case (i)
      4'd8:    return sfx[15:8];
      4'd9:    return sfx[7:0];
      default: return nib2ascii(sh[31:28]);
    endcase
  endfunction

  assign word_ext = 32'(word);
  assign done     = vld_tx & rdy_tx & (idx == LAST_IDX);

  // d_tx is only reloaded on start or on a completed transfer, so it holds while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q <= '0;
      idx    <= '0;
      vld_tx <= 1'b0;
      d_tx   <= '0;
    end else if (start) begin
      word_q <= word_ext;
      idx    <= '0;
      vld_tx <= 1'b1;
      d_tx   <= byte_sel(word_ext, 4'd0, suffix);
    end else if (vld_tx && rdy_tx) begin
      if (idx == LAST_IDX) begin
        vld_tx <= 1'b0;
      end else begin
        idx  <= idx + 4'd1;
        d_tx <= byte_sel(word_q, idx + 4'd1, suffix);
      end
    end
  end

endmodule

// File: rtl/dcp_mem_write.sv
// Memory-write debug command: parses a hex address, then repeatedly prompts
// "AAAAAAAA: ", reads a hex data word and writes it, until an empty data token.
module dcp_mem_write
  import dcp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] end_addr,
  output logic              finish,
  input  logic [7:0]        d_rx,
  input  logic              vld_rx,
  output logic              rdy_rx,
  output logic [7:0]        d_tx,
  output logic              vld_tx,
  input  logic              rdy_tx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we
);

  // RX: a byte moves when vld_rx & rdy_rx at a rising edge; TX likewise with vld_tx & rdy_tx.
  dcp_state_e        state, state_d;
  logic [DATA_W-1:0] acc, acc_d;
  logic              seen, seen_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic              mem_we_d, finish_d;
  logic [ADDR_W-1:0] mem_addr_d, end_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              tx_start, tx_done;
  logic              rx_fire, rx_term;

  dcp_word_tx #(.WORD_W(ADDR_W)) u_word_tx (
    .clk    (clk),
    .rstn   (rstn),
    .start  (tx_start),
    .word   (addr_d),
    .suffix ({COLON, SPACE}),
    .d_tx   (d_tx),
    .vld_tx (vld_tx),
    .rdy_tx (rdy_tx),
    .done   (tx_done)
  );

  always_comb begin
    rdy_rx      = (state == S_SCAN_A) || (state == S_SCAN_D);
    rx_fire     = vld_rx & rdy_rx;
    rx_term     = rx_fire & is_term(d_rx);
    state_d     = state;
    acc_d       = acc;
    seen_d      = seen;
    addr_d      = addr;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    finish_d    = 1'b0;
    end_addr_d  = end_addr;
    tx_start    = 1'b0;

    // Non-hex, non-terminator bytes fall through untouched.
    if (rx_fire && is_hex(d_rx)) begin
      acc_d  = {acc[DATA_W-5:0], ascii2nib(d_rx)};
      seen_d = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (we) begin
          state_d = S_SCAN_A;
          acc_d   = '0;
          seen_d  = 1'b0;
        end
      end
      S_SCAN_A: begin
        if (rx_term) begin
          addr_d   = seen ? acc[ADDR_W-1:0] : last_addr;
          acc_d    = '0;
          seen_d   = 1'b0;
          tx_start = 1'b1;
          state_d  = S_PROMPT;
        end
      end
      S_PROMPT: begin
        if (tx_done) state_d = S_SCAN_D;
      end
      S_SCAN_D: begin
        if (rx_term) begin
          acc_d  = '0;
          seen_d = 1'b0;
          if (seen) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr;
            mem_wdata_d = acc;
            state_d     = S_WRITE;
          end else begin
            finish_d   = 1'b1;
            end_addr_d = addr;
            state_d    = S_DONE;
          end
        end
      end
      S_WRITE: begin
        // The prompt for the next address starts while mem_we is high.
        addr_d   = addr + ADDR_W'(ADDR_STEP);
        tx_start = 1'b1;
        state_d  = S_PROMPT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      acc       <= '0;
      seen      <= 1'b0;
      addr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      finish    <= 1'b0;
      end_addr  <= '0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      seen      <= seen_d;
      addr      <= addr_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      finish    <= finish_d;
      end_addr  <= end_addr_d;
    end
  end

endmodule
